// File: rtl/firefly_flash_rx_if.sv
// Sentry-flash receiver bus.
// Groups the flash line, the count-clear request and every status output of
// the receiver so that the receiver and its observer share one connection.
//   f1         sentry flash line (asynchronous to clk)
//   cnt_clr    synchronous clear of flash_cnt
//   flash_ok   one-cycle pulse: valid flash completed
//   flash_err  one-cycle pulse: malformed flash (short or stuck high)
//   busy       high while a pulse is being measured or is stuck
//   flash_cnt  saturating valid-flash count
//   last_width width of the most recently measured pulse
// Modports:
//   master  the observer side (drives f1/cnt_clr, reads status)
//   slave   the receiver side (reads f1/cnt_clr, drives status)
interface firefly_flash_rx_if #(
  parameter int CW = 16
);
  logic          f1;
  logic          cnt_clr;
  logic          flash_ok;
  logic          flash_err;
  logic          busy;
  logic [7:0]    flash_cnt;
  logic [CW-1:0] last_width;

  modport master (
    output f1,
    output cnt_clr,
    input  flash_ok,
    input  flash_err,
    input  busy,
    input  flash_cnt,
    input  last_width
  );

  modport slave (
    input  f1,
    input  cnt_clr,
    output flash_ok,
    output flash_err,
    output busy,
    output flash_cnt,
    output last_width
  );
endinterface

// File: rtl/firefly_flash_rx.sv
// Receiving end of the sentry-flash link.
// Synchronises the flash line f1, measures the width of every high pulse and
// classifies it as a valid flash (FLASH_LEN +/- TOL cycles) or a fault (too
// short, or stuck high). Keeps a saturating count of valid flashes.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    firefly_flash_rx_if slave modport (f1, cnt_clr in; flash_ok,
//          flash_err, busy, flash_cnt, last_width out)
module firefly_flash_rx #(
  parameter int FLASH_LEN = 15000,
  parameter int TOL       = 16,
  parameter int CW        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  firefly_flash_rx_if.slave  bus
);

  localparam logic [CW-1:0] W_MIN   = CW'(FLASH_LEN - TOL);
  localparam logic [CW-1:0] W_HI    = CW'(FLASH_LEN + TOL);
  // First width that can no longer be a valid flash while still high.
  localparam logic [CW-1:0] W_STUCK = CW'(FLASH_LEN + TOL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          sync1_reg, s_reg, s_d_reg;
  logic          rise, fall;
  logic [CW-1:0] wcnt_reg, wcnt_next, wcnt_inc;
  logic [CW-1:0] last_width_reg, last_width_next;
  logic          ok_reg, ok_next;
  logic          err_reg, err_next;
  logic          busy_reg;
  logic [7:0]    cnt_reg;

  // Synchroniser and edge-detect history. These reset high so that a pulse
  // already present at reset release never produces a rise, and its falling
  // edge lands in IDLE where it is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      s_reg     <= 1'b1;
      s_d_reg   <= 1'b1;
    end else begin
      sync1_reg <= bus.f1;
      s_reg     <= sync1_reg;
      s_d_reg   <= s_reg;
    end
  end

  assign rise     = s_reg & ~s_d_reg;
  assign fall     = ~s_reg & s_d_reg;
  assign wcnt_inc = wcnt_reg + 1'b1;

  // Next-state and measurement logic.
  always_comb begin
    state_next      = state_reg;
    wcnt_next       = wcnt_reg;
    last_width_next = last_width_reg;
    ok_next         = 1'b0;
    err_next        = 1'b0;
    case (state_reg)
      IDLE: begin
        // The rise cycle is itself the first high cycle of the pulse.
        if (rise) begin
          state_next = MEAS;
          wcnt_next  = CW'(1);
        end
      end
      MEAS: begin
        // s_d is always high in MEAS, so s low here is exactly a fall.
        if (s_reg) begin
          wcnt_next = wcnt_inc;
          if (wcnt_inc == W_STUCK) begin
            state_next      = STUCK;
            err_next        = 1'b1;
            last_width_next = W_STUCK;
          end
        end else begin
          state_next      = IDLE;
          last_width_next = wcnt_reg;
          if (wcnt_reg >= W_MIN && wcnt_reg <= W_HI) begin
            ok_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      STUCK: begin
        // Already reported; wait silently for the line to drop.
        if (fall) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wcnt_reg       <= '0;
      last_width_reg <= '0;
      ok_reg         <= 1'b0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wcnt_reg       <= wcnt_next;
      last_width_reg <= last_width_next;
      ok_reg         <= ok_next;
      err_reg        <= err_next;
      busy_reg       <= (state_next != IDLE);
    end
  end

  // Valid-flash counter follows the registered flash_ok pulse, so a clear
  // asserted while flash_ok is visible wins over that increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 8'd0;
    end else if (bus.cnt_clr) begin
      cnt_reg <= 8'd0;
    end else if (ok_reg && cnt_reg != 8'hFF) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign bus.flash_ok   = ok_reg;
  assign bus.flash_err  = err_reg;
  assign bus.busy       = busy_reg;
  assign bus.flash_cnt  = cnt_reg;
  assign bus.last_width = last_width_reg;

endmodule

// File: tb/tb_firefly_flash_rx.sv
module tb_firefly_flash_rx;
  localparam int FLASH_LEN = 64;
  localparam int TOL       = 4;
  localparam int CW        = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  firefly_flash_rx_if #(.CW(CW)) bus ();

  firefly_flash_rx #(
    .FLASH_LEN (FLASH_LEN),
    .TOL       (TOL),
    .CW        (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ok_total = 0;
  int err_total = 0;
  int both_total = 0;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.flash_ok)                  ok_total   <= ok_total + 1;
    if (bus.flash_err)                 err_total  <= err_total + 1;
    if (bus.flash_ok && bus.flash_err) both_total <= both_total + 1;
  end

  typedef struct {
    int width;
    int exp_ok;
    int exp_err;
    int exp_lw;
    int exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int w);
    bus.f1 = 1'b1;
    tick(w);
    bus.f1 = 1'b0;
  endtask

  int ob, eb;
  bit found;

  initial begin
    vecs[0] = '{width: 60, exp_ok: 1, exp_err: 0, exp_lw: 60, exp_cnt: 2};
    vecs[1] = '{width: 68, exp_ok: 1, exp_err: 0, exp_lw: 68, exp_cnt: 3};
    vecs[2] = '{width: 59, exp_ok: 0, exp_err: 1, exp_lw: 59, exp_cnt: 3};
    vecs[3] = '{width: 10, exp_ok: 0, exp_err: 1, exp_lw: 10, exp_cnt: 3};
    vecs[4] = '{width: 1,  exp_ok: 0, exp_err: 1, exp_lw: 1,  exp_cnt: 3};
    vecs[5] = '{width: 69, exp_ok: 0, exp_err: 1, exp_lw: 69, exp_cnt: 3};

    bus.f1 = 1'b0;
    bus.cnt_clr = 1'b0;
    rst_n = 1'b0;
    tick(3);
    check("rst_ok",   int'(bus.flash_ok),   0);
    check("rst_err",  int'(bus.flash_err),  0);
    check("rst_busy", int'(bus.busy),       0);
    check("rst_cnt",  int'(bus.flash_cnt),  0);
    check("rst_lw",   int'(bus.last_width), 0);
    $display("reset: ok=%0d err=%0d busy=%0d cnt=%0d lw=%0d", bus.flash_ok,
             bus.flash_err, bus.busy, bus.flash_cnt, bus.last_width);
    rst_n = 1'b1;
    tick(3);

    // Nominal flash with exact output latency.
    ob = ok_total;
    bus.f1 = 1'b1;
    tick(10);
    check("busy_meas", int'(bus.busy), 1);
    tick(FLASH_LEN - 10);
    bus.f1 = 1'b0;
    tick(1);
    check("lat_e1", int'(bus.flash_ok), 0);
    tick(1);
    check("lat_e2", int'(bus.flash_ok), 0);
    tick(1);
    check("lat_e3", int'(bus.flash_ok), 1);
    tick(1);
    check("lat_e4", int'(bus.flash_ok), 0);
    tick(3);
    check("nom_okcnt", ok_total - ob, 1);
    check("nom_cnt",  int'(bus.flash_cnt),  1);
    check("nom_lw",   int'(bus.last_width), FLASH_LEN);
    check("nom_busy", int'(bus.busy),       0);
    $display("nominal: width=%0d lw=%0d cnt=%0d", FLASH_LEN, bus.last_width, bus.flash_cnt);

    // Width table: tolerance edges, short pulses, exact stuck threshold.
    foreach (vecs[i]) begin
      ob = ok_total;
      eb = err_total;
      pulse(vecs[i].width);
      tick(8);
      check($sformatf("v%0d_ok", i),   ok_total - ob,          vecs[i].exp_ok);
      check($sformatf("v%0d_err", i),  err_total - eb,         vecs[i].exp_err);
      check($sformatf("v%0d_lw", i),   int'(bus.last_width),   vecs[i].exp_lw);
      check($sformatf("v%0d_cnt", i),  int'(bus.flash_cnt),    vecs[i].exp_cnt);
      check($sformatf("v%0d_busy", i), int'(bus.busy),         0);
      $display("vec %0d: width=%0d ok=%0d err=%0d lw=%0d cnt=%0d", i, vecs[i].width,
               ok_total - ob, err_total - eb, bus.last_width, bus.flash_cnt);
    end

    // Stuck high: error while still high, nothing on the fall.
    ob = ok_total;
    eb = err_total;
    bus.f1 = 1'b1;
    tick(80);
    check("stuck_err_early", err_total - eb, 1);
    check("stuck_lw",   int'(bus.last_width), FLASH_LEN + TOL + 1);
    check("stuck_busy", int'(bus.busy), 1);
    tick(20);
    bus.f1 = 1'b0;
    tick(8);
    check("stuck_err_total", err_total - eb, 1);
    check("stuck_ok", ok_total - ob, 0);
    check("stuck_busy_end", int'(bus.busy), 0);
    $display("stuck: width=100 err=%0d lw=%0d", err_total - eb, bus.last_width);

    // Reset in the middle of a pulse, released while still high.
    ob = ok_total;
    eb = err_total;
    bus.f1 = 1'b1;
    tick(30);
    rst_n = 1'b0;
    tick(2);
    check("midrst_cnt",  int'(bus.flash_cnt),  0);
    check("midrst_lw",   int'(bus.last_width), 0);
    check("midrst_busy", int'(bus.busy),       0);
    rst_n = 1'b1;
    tick(20);
    bus.f1 = 1'b0;
    tick(8);
    check("midrst_ok",  ok_total - ob,  0);
    check("midrst_err", err_total - eb, 0);
    pulse(FLASH_LEN);
    tick(8);
    check("midrst_next_ok",  ok_total - ob,       1);
    check("midrst_next_cnt", int'(bus.flash_cnt), 1);
    $display("midreset: ok=%0d err=%0d cnt=%0d", ok_total - ob, err_total - eb, bus.flash_cnt);

    // Back-to-back pulses with a single low cycle between them.
    ob = ok_total;
    pulse(FLASH_LEN);
    tick(1);
    pulse(FLASH_LEN);
    tick(8);
    check("b2b_ok",  ok_total - ob,       2);
    check("b2b_cnt", int'(bus.flash_cnt), 3);
    $display("back2back: ok=%0d cnt=%0d", ok_total - ob, bus.flash_cnt);

    // Saturation, then clear coinciding with flash_ok.
    ob = ok_total;
    for (int k = 0; k < 300; k++) begin
      pulse(FLASH_LEN);
      tick(6);
    end
    tick(4);
    check("sat_ok",  ok_total - ob,       300);
    check("sat_cnt", int'(bus.flash_cnt), 255);
    $display("saturate: ok=%0d cnt=%0d", ok_total - ob, bus.flash_cnt);

    pulse(FLASH_LEN);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick(1);
      if (bus.flash_ok) found = 1'b1;
    end
    check("clr_ok_seen", int'(found), 1);
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    tick(2);
    check("clr_cnt", int'(bus.flash_cnt), 0);
    $display("clear: ok_seen=%0d cnt=%0d", found, bus.flash_cnt);

    check("ok_err_overlap", both_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
